ntt_bitrev_unloader: RTL and testbench

Output-side reorder buffer for the NTT datapath. Consumes the coefficient stream leaving the final butterfly/Montgomery stage in bit-reversed order and re-emits it in natural order over a valid/ready interface. Applies a final conditional modular subtraction so every emitted coefficient is fully reduced into [0, MODULUS). Ping-pong banking sustains one coefficient per cycle in steady state.

---
 rtl/ntt_bitrev_unloader_if.sv | 23 ++
 rtl/ntt_bitrev_unloader.sv | 99 +++++++++
 tb/tb_ntt_bitrev_unloader.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_bitrev_unloader_if.sv
// Stream bus for the NTT output reorder buffer: bit-reversed input side and
// natural-order output side, each with its own valid/ready handshake.
interface ntt_bitrev_unloader_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ntt_bitrev_unloader.sv
// Ping-pong reorder buffer: stores bit-reversed NTT coefficients after a final
// conditional subtraction and replays them in natural order.
module ntt_bitrev_unloader #(
  parameter int W       = 32,
  parameter int N       = 8,
  parameter int MODULUS = 7681
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ntt_bitrev_unloader_if.slave  bus,
  output logic                  range_err,
  output logic                  busy
);
  localparam int LOG = $clog2(N);

  localparam logic [1:0] EMPTY    = 2'd0;
  localparam logic [1:0] FILLING  = 2'd1;
  localparam logic [1:0] FULL     = 2'd2;
  localparam logic [1:0] DRAINING = 2'd3;

  localparam logic [W-1:0]   MOD  = W'(MODULUS);
  localparam logic [W-1:0]   MOD2 = W'(2 * MODULUS);
  localparam logic [LOG-1:0] LAST = LOG'(N - 1);

  logic [W-1:0]   mem [2][N];
  logic [1:0]     st  [2];
  logic           wb;
  logic           rb;
  logic [LOG-1:0] wcnt;
  logic [LOG-1:0] rcnt;

  logic           in_rdy;
  logic           out_vld;
  logic           wr_hs;
  logic           rd_hs;
  logic [W-1:0]   red_data;

  function automatic logic [LOG-1:0] bitrev(input logic [LOG-1:0] a);
    logic [LOG-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG; i++) begin
      r[i] = a[LOG-1-i];
    end
    return r;
  endfunction

  // Ready/valid come only from registered bank state, so a bank freed by the
  // last read becomes writable one cycle later.
  always_comb begin
    in_rdy        = (st[wb] == EMPTY) || (st[wb] == FILLING);
    out_vld       = (st[rb] == FULL) || (st[rb] == DRAINING);
    wr_hs         = bus.in_valid && in_rdy;
    rd_hs         = out_vld && bus.out_ready;
    red_data      = (bus.in_data >= MOD) ? (bus.in_data - MOD) : bus.in_data;
    bus.in_ready  = in_rdy;
    bus.out_valid = out_vld;
    bus.out_data  = mem[rb][rcnt];
    bus.out_last  = out_vld && (rcnt == LAST);
    busy          = (st[0] != EMPTY) || (st[1] != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (wr_hs) begin
      mem[wb][bitrev(wcnt)] <= red_data;
    end
  end

  // A write handshake and a read handshake never target the same bank, since
  // their enabling state sets are disjoint; both updates may land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st[0]     <= EMPTY;
      st[1]     <= EMPTY;
      wb        <= 1'b0;
      rb        <= 1'b0;
      wcnt      <= '0;
      rcnt      <= '0;
      range_err <= 1'b0;
    end else begin
      if (wr_hs) begin
        st[wb] <= (wcnt == LAST) ? FULL : FILLING;
        wcnt   <= wcnt + 1'b1;
        if (wcnt == LAST) begin
          wb <= ~wb;
        end
        if (bus.in_data >= MOD2) begin
          range_err <= 1'b1;
        end
      end
      if (rd_hs) begin
        st[rb] <= (rcnt == LAST) ? EMPTY : DRAINING;
        rcnt   <= rcnt + 1'b1;
        if (rcnt == LAST) begin
          rb <= ~rb;
        end
      end
    end
  end
endmodule

// File: tb/tb_ntt_bitrev_unloader.sv
// Randomised self-checking bench for ntt_bitrev_unloader against a
// frame-level reorder-and-reduce reference model.
module tb_ntt_bitrev_unloader;
  localparam int W   = 32;
  localparam int N   = 8;
  localparam int MOD = 7681;
  localparam int LOG = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic range_err;
  logic busy;

  int n_checks  = 0;
  int n_pass    = 0;
  int push_fail = 0;

  ntt_bitrev_unloader_if #(.W(W)) bus ();

  ntt_bitrev_unloader #(.W(W), .N(N), .MODULUS(MOD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .range_err (range_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int rev(input int idx);
    int r = 0;
    int v = idx;
    for (int k = 0; k < LOG; k++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] red_m(input logic [W-1:0] x);
    return (x >= MOD) ? x - MOD : x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, output bit ok);
    bit hs;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 200; t++) begin
      hs = bus.in_ready;
      tick();
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) push_fail++;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_last !== 1'b0) $display("FAIL rst_out_last got %b exp 0", bus.out_last); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (range_err !== 1'b0) $display("FAIL rst_range_err got %b exp 0", range_err); else n_pass++;
  endtask

  task automatic test_single_frame();
    bit ok;
    logic [W-1:0] exp_v;
    do_reset();
    bus.out_ready = 1'b1;
    for (int j = 0; j < N; j++) begin
      if (j == N - 1) begin
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL sf_early_valid got %b exp 0", bus.out_valid); else n_pass++;
      end
      push(W'(100 + j), ok);
    end
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL sf_latency got %b exp 1", bus.out_valid); else n_pass++;
    for (int i = 0; i < N; i++) begin
      exp_v = W'(100 + rev(i));
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_v || bus.out_last !== (i == N - 1))
        $display("FAIL sf_word%0d got v=%b d=%0d l=%b exp v=1 d=%0d l=%b", i, bus.out_valid, bus.out_data, bus.out_last, exp_v, (i == N - 1));
      else n_pass++;
      tick();
    end
    n_checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL sf_idle got v=%b busy=%b exp 0 0", bus.out_valid, busy); else n_pass++;
    n_checks++; if (push_fail != 0) $display("FAIL sf_push_timeout got %0d exp 0", push_fail); else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reduction();
    bit ok;
    logic [W-1:0] frame [N];
    logic [W-1:0] exp_v;
    do_reset();
    for (int j = 0; j < N; j++) frame[j] = W'($urandom_range(2 * MOD - 1, 0));
    frame[1] = 7680;
    frame[2] = 7681;
    frame[5] = 15361;
    frame[6] = 0;
    bus.out_ready = 1'b1;
    for (int j = 0; j < N; j++) push(frame[j], ok);
    for (int i = 0; i < N; i++) begin
      exp_v = red_m(frame[rev(i)]);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_v)
        $display("FAIL red_word%0d got v=%b d=%0d exp v=1 d=%0d", i, bus.out_valid, bus.out_data, exp_v);
      else n_pass++;
      tick();
    end
    n_checks++; if (range_err !== 1'b0) $display("FAIL red_range_err got %b exp 0", range_err); else n_pass++;
    n_checks++; if (push_fail != 0) $display("FAIL red_push_timeout got %0d exp 0", push_fail); else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_range_err();
    bit ok;
    logic [W-1:0] frame [N];
    logic [W-1:0] exp_v;
    do_reset();
    for (int j = 0; j < N; j++) frame[j] = W'($urandom_range(2 * MOD - 1, 0));
    frame[3] = 15362;
    bus.out_ready = 1'b1;
    for (int j = 0; j < N; j++) begin
      if (j == 3) begin
        n_checks++; if (range_err !== 1'b0) $display("FAIL re_before got %b exp 0", range_err); else n_pass++;
      end
      push(frame[j], ok);
      if (j == 3) begin
        n_checks++; if (range_err !== 1'b1) $display("FAIL re_rise got %b exp 1", range_err); else n_pass++;
      end
    end
    for (int i = 0; i < N; i++) begin
      exp_v = red_m(frame[rev(i)]);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_v)
        $display("FAIL re_word%0d got v=%b d=%0d exp v=1 d=%0d", i, bus.out_valid, bus.out_data, exp_v);
      else n_pass++;
      tick();
    end
    for (int k = 0; k < 5; k++) tick();
    n_checks++; if (range_err !== 1'b1) $display("FAIL re_sticky got %b exp 1", range_err); else n_pass++;
    do_reset();
    n_checks++; if (range_err !== 1'b0) $display("FAIL re_clear got %b exp 0", range_err); else n_pass++;
    n_checks++; if (push_fail != 0) $display("FAIL re_push_timeout got %0d exp 0", push_fail); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [W-1:0] frame [3][N];
    logic [W-1:0] q[$];
    do_reset();
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < N; j++) frame[f][j] = W'($urandom_range(2 * MOD - 1, 0));
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) q.push_back(red_m(frame[f][rev(i)]));
    for (int f = 0; f < 2; f++)
      for (int j = 0; j < N; j++) push(frame[f][j], ok);
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_full got %b exp 0", bus.in_ready); else n_pass++;
    for (int k = 0; k < 3; k++) tick();
    n_checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL bp_hold got rdy=%b busy=%b exp 0 1", bus.in_ready, busy); else n_pass++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== q[0] || bus.in_ready !== 1'b0)
        $display("FAIL bp_f0_word%0d got v=%b d=%0d rdy=%b exp v=1 d=%0d rdy=0", i, bus.out_valid, bus.out_data, bus.in_ready, q[0]);
      else n_pass++;
      void'(q.pop_front());
      tick();
    end
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release got %b exp 1", bus.in_ready); else n_pass++;
    fork
      begin
        for (int j = 0; j < N; j++) push(frame[2][j], ok);
      end
      begin
        int got = 0;
        for (int c = 0; c < 200 && got < 2 * N; c++) begin
          if (bus.out_valid) begin
            n_checks++;
            if (bus.out_data !== q[got]) $display("FAIL bp_word%0d got %0d exp %0d", got + N, bus.out_data, q[got]);
            else n_pass++;
            got++;
          end
          tick();
        end
        n_checks++; if (got != 2 * N) $display("FAIL bp_count got %0d exp %0d", got, 2 * N); else n_pass++;
      end
    join
    n_checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_idle got v=%b busy=%b exp 0 0", bus.out_valid, busy); else n_pass++;
    n_checks++; if (push_fail != 0) $display("FAIL bp_push_timeout got %0d exp 0", push_fail); else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random_stalls();
    localparam int FRAMES = 100;
    logic [W-1:0] in_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] frame [N];
    do_reset();
    for (int f = 0; f < FRAMES; f++) begin
      for (int j = 0; j < N; j++) begin
        frame[j] = W'($urandom_range(2 * MOD - 1, 0));
        in_q.push_back(frame[j]);
      end
      for (int i = 0; i < N; i++) exp_q.push_back(red_m(frame[rev(i)]));
    end
    fork
      begin
        bit ok;
        foreach (in_q[k]) begin
          if ($urandom_range(3) == 0) tick();
          push(in_q[k], ok);
          if (!ok) break;
        end
      end
      begin
        int got = 0;
        bit pend = 1'b0;
        logic [W-1:0] held = '0;
        for (int c = 0; c < 20000 && got < FRAMES * N; c++) begin
          if (pend) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held)
              $display("FAIL rs_stall_hold got v=%b d=%0d exp v=1 d=%0d", bus.out_valid, bus.out_data, held);
            else n_pass++;
          end
          bus.out_ready = 1'($urandom_range(1));
          pend = 1'b0;
          if (bus.out_valid) begin
            if (bus.out_ready) begin
              n_checks++;
              if (bus.out_data !== exp_q[got] || bus.out_last !== (got % N == N - 1))
                $display("FAIL rs_word%0d got d=%0d l=%b exp d=%0d l=%b", got, bus.out_data, bus.out_last, exp_q[got], (got % N == N - 1));
              else n_pass++;
              got++;
            end else begin
              pend = 1'b1;
              held = bus.out_data;
            end
          end
          tick();
        end
        n_checks++; if (got != FRAMES * N) $display("FAIL rs_count got %0d exp %0d", got, FRAMES * N); else n_pass++;
        bus.out_ready = 1'b0;
      end
    join
    n_checks++; if (push_fail != 0) $display("FAIL rs_push_timeout got %0d exp 0", push_fail); else n_pass++;
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [W-1:0] frame [N];
    logic [W-1:0] exp_v;
    do_reset();
    for (int j = 0; j < 5; j++) push(W'($urandom_range(2 * MOD - 1, 0)), ok);
    n_checks++; if (busy !== 1'b1) $display("FAIL ar_fill_busy got %b exp 1", busy); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL ar_fill_reset got busy=%b rdy=%b v=%b exp 0 1 0", busy, bus.in_ready, bus.out_valid);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < N; j++) push(W'($urandom_range(2 * MOD - 1, 0)), ok);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL ar_drain_valid got %b exp 1", bus.out_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL ar_drain_reset got v=%b l=%b busy=%b rdy=%b exp 0 0 0 1", bus.out_valid, bus.out_last, busy, bus.in_ready);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < N; j++) frame[j] = W'($urandom_range(2 * MOD - 1, 0));
    bus.out_ready = 1'b1;
    for (int j = 0; j < N; j++) push(frame[j], ok);
    for (int i = 0; i < N; i++) begin
      exp_v = red_m(frame[rev(i)]);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_v || bus.out_last !== (i == N - 1))
        $display("FAIL ar_word%0d got v=%b d=%0d l=%b exp v=1 d=%0d l=%b", i, bus.out_valid, bus.out_data, bus.out_last, exp_v, (i == N - 1));
      else n_pass++;
      tick();
    end
    n_checks++; if (push_fail != 0) $display("FAIL ar_push_timeout got %0d exp 0", push_fail); else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_reduction();
    test_range_err();
    test_backpressure();
    test_random_stalls();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
